// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - request/response sequencer driving a combinational ALU, with MUL done as repeated adds
//
// Ports:
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready      command handshake; req_cmd/req_a/req_b sampled on acceptance
//   rsp_valid/rsp_ready      response handshake; rsp_data/rsp_z/rsp_err held stable while pending
//   alu_ain/alu_bin/alu_op   registered drive to the ALU (00 add, 01 sub, 10 and, 11 not-B)
//   alu_out/alu_z            ALU result and zero flag, same cycle
//   busy                     high whenever a command is in flight or its response is pending
module alu_issue_ctrl #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_cmd,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_z,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] alu_ain,
    output logic [DATA_WIDTH-1:0] alu_bin,
    output logic [1:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_z,
    output logic                  busy
);

    localparam logic [2:0] CMD_ADD = 3'b000;
    localparam logic [2:0] CMD_SUB = 3'b001;
    localparam logic [2:0] CMD_AND = 3'b010;
    localparam logic [2:0] CMD_MVN = 3'b011;
    localparam logic [2:0] CMD_CMP = 3'b100;
    localparam logic [2:0] CMD_MUL = 3'b101;

    localparam logic [DATA_WIDTH-1:0] ZERO = '0;
    localparam logic [DATA_WIDTH-1:0] ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MULT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] cnt;
    logic                  is_cmp;
    logic                  accept;

    assign accept = req_valid && (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    case (req_cmd)
                        CMD_ADD, CMD_SUB, CMD_AND, CMD_MVN, CMD_CMP: state_nxt = EXEC;
                        CMD_MUL: state_nxt = (req_b != ZERO) ? MULT : RESP;
                        default: state_nxt = RESP;
                    endcase
                end
            end
            EXEC: state_nxt = RESP;
            MULT: begin
                if (cnt == ONE) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_ain  <= '0;
            alu_bin  <= '0;
            alu_op   <= 2'b00;
            cnt      <= '0;
            is_cmp   <= 1'b0;
            rsp_data <= '0;
            rsp_z    <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_cmp <= (req_cmd == CMD_CMP);
                        case (req_cmd)
                            CMD_ADD, CMD_SUB, CMD_AND, CMD_MVN: begin
                                alu_ain <= req_a;
                                alu_bin <= req_b;
                                alu_op  <= req_cmd[1:0];
                            end
                            CMD_CMP: begin
                                alu_ain <= req_a;
                                alu_bin <= req_b;
                                alu_op  <= 2'b01;
                            end
                            CMD_MUL: begin
                                if (req_b != ZERO) begin
                                    // Accumulator starts at zero; multiplicand rides on Bin.
                                    alu_ain <= '0;
                                    alu_bin <= req_a;
                                    alu_op  <= 2'b00;
                                    cnt     <= req_b;
                                end else begin
                                    rsp_data <= '0;
                                    rsp_z    <= 1'b1;
                                    rsp_err  <= 1'b0;
                                end
                            end
                            default: begin
                                rsp_data <= '0;
                                rsp_z    <= 1'b0;
                                rsp_err  <= 1'b1;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    // CMP only reports the flag; the data word echoes operand A.
                    rsp_data <= is_cmp ? alu_ain : alu_out;
                    rsp_z    <= alu_z;
                    rsp_err  <= 1'b0;
                end
                MULT: begin
                    alu_ain <= alu_out;
                    cnt     <= cnt - ONE;
                    if (cnt == ONE) begin
                        rsp_data <= alu_out;
                        rsp_z    <= alu_z;
                        rsp_err  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed scoreboard bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_z;
    logic        rsp_err;
    logic [15:0] alu_ain;
    logic [15:0] alu_bin;
    logic [1:0]  alu_op;
    logic [15:0] alu_out;
    logic        alu_z;
    logic        busy;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [15:0] data;
        logic        z;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    alu_issue_ctrl #(.DATA_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_z     (rsp_z),
        .rsp_err   (rsp_err),
        .alu_ain   (alu_ain),
        .alu_bin   (alu_bin),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .alu_z     (alu_z),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU seen by the sequencer.
    always_comb begin
        alu_out = 16'h0000;
        case (alu_op)
            2'b00: alu_out = alu_ain + alu_bin;
            2'b01: alu_out = alu_ain - alu_bin;
            2'b10: alu_out = alu_ain & alu_bin;
            2'b11: alu_out = ~alu_bin;
            default: alu_out = 16'h0000;
        endcase
        alu_z = (alu_out == 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one request, record its expected response, and return one cycle
    // after the acceptance edge with operands scrambled.
    task automatic send(input logic [2:0] cmd, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ed, input logic ez, input logic eerr, input int elat);
        exp_t e;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_a     = a;
        req_b     = b;
        e.data = ed;
        e.z    = ez;
        e.err  = eerr;
        e.lat  = elat;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = 16'd100;
        req_b     = 16'($urandom);
        req_cmd   = 3'($urandom);
    endtask

    // Wait for the response, compare it to the scoreboard head, optionally hold
    // it under back-pressure while a competing request is offered, then complete it.
    task automatic collect(input int hold);
        exp_t e;
        int   lat;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("rsp_latency", lat, e.lat);
            check("rsp_data", rsp_data, e.data);
            check("rsp_z", rsp_z, e.z);
            check("rsp_err", rsp_err, e.err);
            for (int i = 0; i < hold; i++) begin
                if (i == 0) begin
                    req_valid = 1'b1;
                    req_cmd   = 3'b000;
                    req_a     = 16'd1;
                    req_b     = 16'd1;
                end
                check("bp_rsp_valid", rsp_valid, 1);
                check("bp_rsp_data", rsp_data, e.data);
                check("bp_req_ready", req_ready, 0);
                @(negedge clk);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("post_hs_rsp_valid", rsp_valid, 0);
        check("post_hs_req_ready", req_ready, 1);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_cmd   = 3'b000;
        req_a     = 16'h0000;
        req_b     = 16'h0000;
        rsp_ready = 1'b1;
        #3;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_z", rsp_z, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_alu_ain", alu_ain, 0);
        check("rst_alu_bin", alu_bin, 0);
        check("rst_alu_op", alu_op, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1);

        // Reset in the middle of a long MUL
        @(negedge clk);
        req_valid = 1'b1;
        req_cmd   = 3'b101;
        req_a     = 16'd2;
        req_b     = 16'd100;
        @(negedge clk);
        req_valid = 1'b0;
        check("mul_busy", busy, 1);
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_alu_ain", alu_ain, 0);
        check("midrst_alu_bin", alu_bin, 0);
        check("midrst_alu_op", alu_op, 0);
        check("midrst_rsp_data", rsp_data, 0);
        check("midrst_req_ready", req_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_rsp", rsp_valid, 0);
        end
        send(3'b000, 16'd1, 16'd1, 16'd2, 1'b0, 1'b0, 2);
        collect(0);

        // Single-cycle operations
        send(3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 2);
        collect(0);
        send(3'b001, 16'd5, 16'd5, 16'h0000, 1'b1, 1'b0, 2);
        collect(0);
        send(3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 2);
        collect(0);
        send(3'b011, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 2);
        collect(0);
        send(3'b100, 16'd7, 16'd7, 16'd7, 1'b1, 1'b0, 2);
        collect(0);
        send(3'b100, 16'd7, 16'd5, 16'd7, 1'b0, 1'b0, 2);
        collect(0);

        // MUL
        send(3'b101, 16'd3, 16'd4, 16'd12, 1'b0, 1'b0, 5);
        collect(0);
        send(3'b101, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 257);
        collect(0);
        send(3'b101, 16'd9, 16'd0, 16'h0000, 1'b1, 1'b0, 1);
        collect(0);
        send(3'b101, 16'd1000, 16'd7, 16'd7000, 1'b0, 1'b0, 8);
        collect(0);

        // Illegal commands
        send(3'b110, 16'd3, 16'd4, 16'h0000, 1'b0, 1'b1, 1);
        collect(0);
        send(3'b000, 16'd2, 16'd3, 16'd5, 1'b0, 1'b0, 2);
        collect(0);
        send(3'b111, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1);
        collect(0);

        // Back-pressure with a competing request held pending
        rsp_ready = 1'b0;
        send(3'b001, 16'd10, 16'd3, 16'd7, 1'b0, 1'b0, 2);
        collect(5);
        // The ADD 1+1 left on the request port is taken on the next edge.
        begin
            exp_t e;
            e.data = 16'd2;
            e.z    = 1'b0;
            e.err  = 1'b0;
            e.lat  = 2;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = 16'd100;
        check("late_accept_busy", busy, 1);
        collect(0);

        // Operand change after acceptance is ignored
        send(3'b000, 16'd4, 16'd4, 16'd8, 1'b0, 1'b0, 2);
        collect(0);

        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
